// File: rtl/cpu_pipechain.sv
// cpu_pipechain: elastic valid/ready register chain with bubble collapsing,
// synchronous flush and an occupancy count.
module cpu_pipechain #(
    parameter int PIPE_WIDTH = 32,
    parameter int PIPE_DEPTH = 2
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [PIPE_WIDTH-1:0]         in_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [PIPE_WIDTH-1:0]         out_data,
    input  logic                          flush,
    output logic [$clog2(PIPE_DEPTH+1)-1:0] count
);
    localparam int CW = $clog2(PIPE_DEPTH + 1);

    logic [PIPE_DEPTH-1:0] v_q, v_d, rdy;
    logic [PIPE_DEPTH:0]   src_v;
    logic [PIPE_WIDTH-1:0] d_q [PIPE_DEPTH];
    logic [PIPE_WIDTH-1:0] d_d [PIPE_DEPTH];
    logic [PIPE_WIDTH-1:0] src_d [PIPE_DEPTH+1];
    logic                  all_v;
    logic [CW-1:0]         cnt;

    // A stage is ready unless it and every stage after it are full with the output stalled.
    always_comb begin
        all_v = 1'b1;
        for (int i = PIPE_DEPTH - 1; i >= 0; i--) begin
            all_v  = all_v & v_q[i];
            rdy[i] = out_ready | ~all_v;
        end
    end

    always_comb begin
        src_v    = {v_q, in_valid};
        src_d[0] = in_data;
        for (int i = 0; i < PIPE_DEPTH; i++) src_d[i+1] = d_q[i];
        v_d = v_q;
        d_d = d_q;
        cnt = '0;
        for (int i = 0; i < PIPE_DEPTH; i++) begin
            cnt = cnt + CW'(v_q[i]);
            if (flush) begin
                v_d[i] = 1'b0;
            end else if (rdy[i]) begin
                v_d[i] = src_v[i];
                if (src_v[i]) d_d[i] = src_d[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v_q <= '0;
            d_q <= '{default: '0};
        end else begin
            v_q <= v_d;
            d_q <= d_d;
        end
    end

    assign in_ready  = rdy[0] & ~flush;
    assign out_valid = v_q[PIPE_DEPTH-1] & ~flush;
    assign out_data  = d_q[PIPE_DEPTH-1];
    assign count     = cnt;
endmodule

// File: tb/tb_cpu_pipechain.sv
// tb_cpu_pipechain: table-driven cycle-by-cycle check of a 3-deep chain,
// plus a hand-written latency sequence.
module tb_cpu_pipechain;
    typedef struct {
        logic        rst_n;
        logic        fl;
        logic        iv;
        logic [31:0] id;
        logic        ordy;
        logic        e_ir;
        logic        e_ov;
        logic [31:0] e_od;
        logic [1:0]  e_cnt;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n, in_valid, in_ready, out_valid, out_ready, flush;
    logic [31:0] in_data, out_data;
    logic [1:0]  count;
    int          errors = 0;
    int          checks = 0;
    vec_t        tv[$];

    cpu_pipechain #(.PIPE_WIDTH(32), .PIPE_DEPTH(3)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .flush(flush), .count(count)
    );

    always #5 clk = ~clk;

    task automatic add(input logic r, input logic f, input logic iv, input logic [31:0] id,
                       input logic ordy, input logic ir, input logic ov, input logic [31:0] od,
                       input logic [1:0] c);
        vec_t t;
        t = '{r, f, iv, id, ordy, ir, ov, od, c};
        tv.push_back(t);
    endtask

    task automatic chk(input string name, input int row, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s row %0d: got %h expected %h", name, row, act, exp);
        end
    endtask

    initial begin
        int n;
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b1; in_data = 32'hFFFF_FFFF; out_ready = 1'b0;
        // reset, streaming 1..8
        add(0,0,1,32'hFFFF_FFFF,0, 1,0,32'h0,0);
        add(1,0,0,32'h0,1, 1,0,32'h0,0);
        add(1,0,1,32'h1,1, 1,0,32'h0,0);
        add(1,0,1,32'h2,1, 1,0,32'h0,1);
        add(1,0,1,32'h3,1, 1,0,32'h0,2);
        add(1,0,1,32'h4,1, 1,1,32'h1,3);
        add(1,0,1,32'h5,1, 1,1,32'h2,3);
        add(1,0,1,32'h6,1, 1,1,32'h3,3);
        add(1,0,1,32'h7,1, 1,1,32'h4,3);
        add(1,0,1,32'h8,1, 1,1,32'h5,3);
        add(1,0,0,32'h0,1, 1,1,32'h6,3);
        add(1,0,0,32'h0,1, 1,1,32'h7,2);
        add(1,0,0,32'h0,1, 1,1,32'h8,1);
        add(1,0,0,32'h0,0, 1,0,32'h8,0);
        // backpressure, push+pop at full
        add(1,0,1,32'hA,0, 1,0,32'h8,0);
        add(1,0,1,32'hB,0, 1,0,32'h8,1);
        add(1,0,1,32'hC,0, 1,0,32'h8,2);
        add(1,0,1,32'hD,0, 0,1,32'hA,3);
        add(1,0,1,32'hD,0, 0,1,32'hA,3);
        add(1,0,1,32'hD,1, 1,1,32'hA,3);
        add(1,0,0,32'h0,0, 0,1,32'hB,3);
        add(1,0,0,32'h0,1, 1,1,32'hB,3);
        add(1,0,0,32'h0,1, 1,1,32'hC,2);
        add(1,0,0,32'h0,1, 1,1,32'hD,1);
        // bubble collapse with output stalled
        add(1,0,1,32'h5,0, 1,0,32'hD,0);
        add(1,0,0,32'h0,0, 1,0,32'hD,1);
        add(1,0,0,32'h0,0, 1,0,32'hD,1);
        add(1,0,1,32'h6,0, 1,1,32'h5,1);
        add(1,0,0,32'h0,0, 1,1,32'h5,2);
        // flush mid-stream
        add(1,1,1,32'h77,0, 0,0,32'h5,2);
        add(1,0,0,32'h0,1, 1,0,32'h5,0);
        // fill, then reset and flush together
        add(1,0,1,32'h11,0, 1,0,32'h5,0);
        add(1,0,1,32'h12,0, 1,0,32'h5,1);
        add(1,0,1,32'h13,0, 1,0,32'h5,2);
        add(0,1,1,32'h14,1, 0,0,32'h11,3);
        add(1,0,1,32'h9,1, 1,0,32'h0,0);
        add(1,0,0,32'h0,1, 1,0,32'h0,1);
        add(1,0,0,32'h0,1, 1,0,32'h0,1);
        add(1,0,0,32'h0,1, 1,1,32'h9,1);
        // flush on empty chain
        add(1,1,0,32'h0,1, 0,0,32'h9,0);
        add(1,0,0,32'h0,1, 1,0,32'h9,0);
        foreach (tv[r]) begin
            @(negedge clk);
            rst_n = tv[r].rst_n; flush = tv[r].fl; in_valid = tv[r].iv;
            in_data = tv[r].id; out_ready = tv[r].ordy;
            #1;
            chk("in_ready",  r, 32'(in_ready),  32'(tv[r].e_ir));
            chk("out_valid", r, 32'(out_valid), 32'(tv[r].e_ov));
            chk("out_data",  r, out_data,       tv[r].e_od);
            chk("count",     r, 32'(count),     32'(tv[r].e_cnt));
        end
        // latency from acceptance edge to out_valid on an empty chain
        @(negedge clk);
        flush = 1'b0; in_valid = 1'b1; in_data = 32'hAB; out_ready = 1'b1;
        #1 chk("lat_accept", 0, 32'(in_ready), 32'h1);
        @(negedge clk);
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("lat_edges", 0, 32'(n), 32'd2);
        chk("lat_data",  0, out_data, 32'hAB);
        @(negedge clk);
        #1 chk("lat_drain", 0, 32'(count), 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
